fractal_sync_mc_fifo: RTL and testbench
=======================================

Name: fractal_sync_mc_fifo

Overview:
- Multi-channel synchronisation FIFO. Next generation of the single-channel fractal-sync FIFO.
- Provides N_CHANNELS independent queues, each with valid/ready on both sides, fill level, almost-full flag and per-channel flush.
- Supports any depth, including non-power-of-two, and optional fall-through (bypass) mode.
- Sits between fractal-sync tree nodes and their per-level request/response ports.

Parameters:
N_CHANNELS, 2, number of independent queues (>=1)
FIFO_DEPTH, 4, entries per channel (>=1, any integer)
DATA_WIDTH, 8, bits per entry
FALL_THROUGH, 1, 1: push into an empty channel is visible at the output in the same cycle; 0: minimum latency is 1 cycle
AFULL_THRESH, 3, almost_full asserted when level >= this value (1..FIFO_DEPTH)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
flush_i  in  N_CHANNELS  per-channel synchronous clear
in_valid_i  in  N_CHANNELS  push request
in_data_i  in  N_CHANNELS x DATA_WIDTH  push data
in_ready_o  out  N_CHANNELS  channel can accept
out_valid_o  out  N_CHANNELS  head entry available
out_data_o  out  N_CHANNELS x DATA_WIDTH  head entry
out_ready_i  in  N_CHANNELS  consumer takes head
level_o  out  N_CHANNELS x LW  entries stored, LW = $clog2(FIFO_DEPTH+1)
almost_full_o  out  N_CHANNELS  level_o >= AFULL_THRESH
error_o  out  N_CHANNELS  sticky protocol error (optional feature only, else tied 0)

Behaviour:
- Reset: on a clock edge with rst_i=1, all channels reach the following state, independent of other inputs: read/write pointers=0, level=0, in_ready_o=1, out_valid_o=0, almost_full_o=0, error_o=0. Storage is not reset. out_data_o is don't-care while out_valid_o=0.
- Channels are fully independent. No cross-channel arbitration.
- Push fires when in_valid_i & in_ready_o. Pop fires when out_valid_o & out_ready_i.
- in_ready_o = (level < FIFO_DEPTH) & ~flush_i. It does not depend on out_ready_i: a full channel refuses a push even if a pop occurs in the same cycle.
- out_valid_o:
  - FALL_THROUGH=0: out_valid_o = (level > 0) & ~flush_i.
  - FALL_THROUGH=1: out_valid_o = ((level > 0) | in_valid_i) & ~flush_i. When level=0, out_data_o = in_data_i.
- Bypass (FALL_THROUGH=1, level=0, push and pop in the same cycle): data goes straight through, is not written to storage, and pointers and level are unchanged.
- Pointers: write and read indices count 0..FIFO_DEPTH-1 and wrap to 0 after FIFO_DEPTH-1 (explicit compare, not power-of-two overflow). Full/empty are derived from a level counter, not pointer MSBs.
- Level update per cycle:
  - push only: +1
  - pop only: -1
  - both: unchanged
  - bypass: unchanged
- Data ordering is strict FIFO per channel.
- Flush: flush_i[c]=1 forces in_ready_o[c]=0 and out_valid_o[c]=0 combinationally. On the next edge, channel c pointers and level return to 0. Flush has priority over any push/pop in that cycle, so no handshake completes on c.
- almost_full_o is registered-state-derived (from level), with no combinational path from inputs.
- Reset during operation: discards all contents. The first push after reset returns that data first.

Optional Feature:
- Macro: FRACTAL_SYNC_MC_FIFO_ERR_CHECK_EN
- Defined:
  - error_o[c] sets on the edge after in_valid_i[c]=1 while level=FIFO_DEPTH (overflow attempt).
  - error_o[c] also sets after out_ready_i[c]=1 with out_valid_o[c]=0 while flush_i[c]=0 (underflow attempt).
  - Sticky; cleared only by rst_i or flush_i[c].
- Undefined: no error logic is synthesised and error_o is constant 0.

Test Plan:
- Reset: assert rst_i 2 cycles with random in_valid_i -> level_o=0, in_ready_o=all 1s, out_valid_o=0, almost_full_o=0.
- Fill/drain, FIFO_DEPTH=3 (non-pow2), FALL_THROUGH=0, channel 0:
  - Push 0x11,0x22,0x33 -> in_ready_o[0]=0, level_o[0]=3, almost_full_o[0]=1.
  - Pop 3 -> outputs 0x11,0x22,0x33 in order, level_o[0]=0.
  - Repeat 5 times to cover pointer wrap.
- Bypass, FALL_THROUGH=1, empty channel 1: in_valid_i=1, in_data_i=0xA5, out_ready_i=1 -> out_valid_o[1]=1 and out_data_o[1]=0xA5 in the same cycle; level_o[1] stays 0.
- Full + simultaneous pop, channel 0 full at depth 4: in_valid_i=1 and out_ready_i=1 -> pop completes, push refused, level_o 4->3. Next cycle push is accepted -> level_o=4.
- Flush isolation: channel 0 level 2, channel 1 level 3; pulse flush_i=2'b01 -> channel 0 level 0, out_valid_o[0]=0; channel 1 level 3 with data intact.
- ERR_CHECK_EN defined: push into a full channel -> error_o[c]=1 next cycle and held; flush_i[c] -> error_o[c]=0.

Source files
------------

// File: rtl/fractal_sync_mc_fifo.sv
// Multi-channel fractal-sync FIFO with per-channel flush, level and almost-full.
// Optional sticky overflow/underflow flags under FRACTAL_SYNC_MC_FIFO_ERR_CHECK_EN.
module fractal_sync_mc_fifo #(
  parameter int unsigned N_CHANNELS   = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned FALL_THROUGH = 1,
  parameter int unsigned AFULL_THRESH = 3,
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_CHANNELS-1:0]          flush_i,
  input  logic [N_CHANNELS-1:0]          in_valid_i,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0] in_data_i,
  output logic [N_CHANNELS-1:0]          in_ready_o,
  output logic [N_CHANNELS-1:0]          out_valid_o,
  output logic [N_CHANNELS*DATA_WIDTH-1:0] out_data_o,
  input  logic [N_CHANNELS-1:0]          out_ready_i,
  output logic [N_CHANNELS*LW-1:0]       level_o,
  output logic [N_CHANNELS-1:0]          almost_full_o,
  output logic [N_CHANNELS-1:0]          error_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_THRESH);
  localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [LW-1:0]         level;
    logic [DATA_WIDTH-1:0] in_data;
    logic [DATA_WIDTH-1:0] head;
    logic empty;
    logic full;
    logic in_rdy;
    logic out_vld;
    logic push;
    logic pop;
    logic bypass;
    logic wr_en;
    logic rd_en;

    assign in_data = in_data_i[c*DATA_WIDTH +: DATA_WIDTH];
    assign empty   = (level == '0);
    assign full    = (level == DEPTH_L);
    assign in_rdy  = ~full & ~flush_i[c];

    if (FALL_THROUGH != 0) begin : g_ft
      assign out_vld = (~empty | in_valid_i[c]) & ~flush_i[c];
      assign head    = empty ? in_data : mem[rptr];
    end else begin : g_nft
      assign out_vld = ~empty & ~flush_i[c];
      assign head    = mem[rptr];
    end

    assign push   = in_valid_i[c] & in_rdy;
    assign pop    = out_vld & out_ready_i[c];
    assign bypass = (FALL_THROUGH != 0) & empty & push & pop;
    assign wr_en  = push & ~bypass;
    assign rd_en  = pop & ~bypass;

    always_ff @(posedge clk_i) begin
      if (wr_en) mem[wptr] <= in_data;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i[c]) begin
        wptr  <= '0;
        rptr  <= '0;
        level <= '0;
      end else begin
        if (wr_en) wptr <= ptr_inc(wptr);
        if (rd_en) rptr <= ptr_inc(rptr);
        if (wr_en && !rd_en)      level <= level + 1'b1;
        else if (rd_en && !wr_en) level <= level - 1'b1;
      end
    end

`ifdef FRACTAL_SYNC_MC_FIFO_ERR_CHECK_EN
    logic err_q;
    always_ff @(posedge clk_i) begin
      if (rst_i || flush_i[c]) begin
        err_q <= 1'b0;
      end else if ((in_valid_i[c] && full) ||
                   (out_ready_i[c] && !out_vld)) begin
        err_q <= 1'b1;
      end
    end
    assign error_o[c] = err_q;
`else
    assign error_o[c] = 1'b0;
`endif

    assign in_ready_o[c]    = in_rdy;
    assign out_valid_o[c]   = out_vld;
    assign out_data_o[c*DATA_WIDTH +: DATA_WIDTH] = head;
    assign level_o[c*LW +: LW] = level;
    assign almost_full_o[c] = (level >= AFULL_L);
  end

endmodule

// File: tb/tb_fractal_sync_mc_fifo.sv
// Directed bench for fractal_sync_mc_fifo: depth-3 registered instance (a)
// and depth-4 fall-through instance (b).
module tb_fractal_sync_mc_fifo;

`ifdef FRACTAL_SYNC_MC_FIFO_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  logic [1:0]  a_fl, a_iv, a_ir, a_ov, a_or, a_af, a_er;
  logic [15:0] a_id, a_od;
  logic [3:0]  a_lv;

  logic [1:0]  b_fl, b_iv, b_ir, b_ov, b_or, b_af, b_er;
  logic [15:0] b_id, b_od;
  logic [5:0]  b_lv;

  fractal_sync_mc_fifo #(
    .N_CHANNELS(2), .FIFO_DEPTH(3), .DATA_WIDTH(8),
    .FALL_THROUGH(0), .AFULL_THRESH(3)
  ) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_fl),
    .in_valid_i(a_iv), .in_data_i(a_id), .in_ready_o(a_ir),
    .out_valid_o(a_ov), .out_data_o(a_od), .out_ready_i(a_or),
    .level_o(a_lv), .almost_full_o(a_af), .error_o(a_er)
  );

  fractal_sync_mc_fifo #(
    .N_CHANNELS(2), .FIFO_DEPTH(4), .DATA_WIDTH(8),
    .FALL_THROUGH(1), .AFULL_THRESH(3)
  ) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_fl),
    .in_valid_i(b_iv), .in_data_i(b_id), .in_ready_o(b_ir),
    .out_valid_o(b_ov), .out_data_o(b_od), .out_ready_i(b_or),
    .level_o(b_lv), .almost_full_o(b_af), .error_o(b_er)
  );

`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    if ((obs) !== (exp)) begin \
      errors++; \
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
    end \
  end

  initial begin
    #200000;
    if (!done) begin
      errors++;
      $error("FAIL timeout: wait expired before end of test");
      $finish;
    end
  end

  initial begin
    logic [7:0] v;
    rst  = 1'b1;
    a_fl = '0; a_or = '0; a_id = '0;
    b_fl = '0; b_or = '0; b_id = '0;
    a_iv = 2'($urandom_range(0, 3));
    b_iv = 2'($urandom_range(0, 3));
    @(posedge clk); #1;
    a_iv = 2'($urandom_range(0, 3));
    b_iv = 2'($urandom_range(0, 3));
    @(posedge clk); #1;
    rst = 1'b0; a_iv = '0; b_iv = '0;
    #1;
    checks++;
    if (a_lv !== 4'h0 || b_lv !== 6'h0 ||
        a_ir !== 2'b11 || b_ir !== 2'b11 ||
        a_ov !== 2'b00 || b_ov !== 2'b00 ||
        a_af !== 2'b00 || b_af !== 2'b00) begin
      errors++;
      $error("FAIL rst_state: lv %0h/%0h rdy %0b/%0b vld %0b/%0b af %0b/%0b",
             a_lv, b_lv, a_ir, b_ir, a_ov, b_ov, a_af, b_af);
    end
    `CHK("rst_a_level", a_lv, 4'h0)
    `CHK("rst_a_ready", a_ir, 2'b11)
    `CHK("rst_a_valid", a_ov, 2'b00)
    `CHK("rst_a_afull", a_af, 2'b00)
    `CHK("rst_a_err",   a_er, 2'b00)
    `CHK("rst_b_level", b_lv, 6'h0)
    `CHK("rst_b_ready", b_ir, 2'b11)
    `CHK("rst_b_valid", b_ov, 2'b00)
    `CHK("rst_b_afull", b_af, 2'b00)

    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 3; k++) begin
        a_iv = 2'b01;
        a_id[7:0] = 8'((k + 1) * 17 + r);
        @(posedge clk); #1;
        checks++;
        if (a_lv[1:0] !== 2'(k + 1)) begin
          errors++;
          $error("FAIL fill_level: observed %0h expected %0h",
                 a_lv[1:0], k + 1);
        end
        checks++;
        if (a_af[0] !== (k == 2)) begin
          errors++;
          $error("FAIL fill_afull: observed %0b at k=%0d", a_af[0], k);
        end
      end
      a_iv = '0; #1;
      `CHK("full_ready", a_ir[0], 1'b0)
      `CHK("full_valid", a_ov[0], 1'b1)
      `CHK("ch1_idle_level", a_lv[3:2], 2'd0)
      for (int k = 0; k < 3; k++) begin
        a_or = 2'b01; #1;
        checks++;
        if (a_od[7:0] !== 8'((k + 1) * 17 + r)) begin
          errors++;
          $error("FAIL drain_data: observed %0h expected %0h",
                 a_od[7:0], 8'((k + 1) * 17 + r));
        end
        @(posedge clk); #1;
      end
      a_or = '0; #1;
      `CHK("drain_level", a_lv[1:0], 2'd0)
      `CHK("drain_valid", a_ov[0], 1'b0)
    end

    b_iv = 2'b10; b_id[15:8] = 8'hA5; b_or = 2'b10; #1;
    `CHK("byp_valid", b_ov[1], 1'b1)
    `CHK("byp_data",  b_od[15:8], 8'hA5)
    `CHK("byp_ready", b_ir[1], 1'b1)
    @(posedge clk); #1;
    b_iv = '0; b_or = '0; #1;
    `CHK("byp_level", b_lv[5:3], 3'd0)
    `CHK("byp_after_valid", b_ov[1], 1'b0)

    for (int k = 0; k < 4; k++) begin
      b_iv = 2'b01; b_id[7:0] = 8'(8'h40 + k);
      @(posedge clk); #1;
    end
    `CHK("b_full_level", b_lv[2:0], 3'd4)
    `CHK("b_full_ready", b_ir[0], 1'b0)
    b_id[7:0] = 8'h44; b_or = 2'b01; #1;
    `CHK("fp_valid", b_ov[0], 1'b1)
    `CHK("fp_data",  b_od[7:0], 8'h40)
    `CHK("fp_ready", b_ir[0], 1'b0)
    @(posedge clk); #1;
    b_or = '0; #1;
    `CHK("fp_level3", b_lv[2:0], 3'd3)
    `CHK("fp_ready_again", b_ir[0], 1'b1)
    @(posedge clk); #1;
    b_iv = '0; #1;
    `CHK("fp_level4", b_lv[2:0], 3'd4)
    for (int k = 0; k < 4; k++) begin
      b_or = 2'b01; #1;
      checks++;
      if (b_od[7:0] !== 8'(8'h41 + k)) begin
        errors++;
        $error("FAIL fp_drain: observed %0h expected %0h",
               b_od[7:0], 8'(8'h41 + k));
      end
      @(posedge clk); #1;
    end
    b_or = '0; #1;
    `CHK("fp_empty", b_lv[2:0], 3'd0)

    for (int k = 0; k < 3; k++) begin
      b_iv = (k < 2) ? 2'b11 : 2'b10;
      b_id = {8'(8'h60 + k), 8'(8'h50 + k)};
      @(posedge clk); #1;
    end
    b_iv = '0; #1;
    `CHK("fl_pre_lv0", b_lv[2:0], 3'd2)
    `CHK("fl_pre_lv1", b_lv[5:3], 3'd3)
    b_fl = 2'b01; b_iv = 2'b01; b_id[7:0] = 8'h55; b_or = 2'b01; #1;
    `CHK("fl_valid0", b_ov[0], 1'b0)
    `CHK("fl_ready0", b_ir[0], 1'b0)
    @(posedge clk); #1;
    b_fl = '0; b_iv = '0; b_or = '0; #1;
    `CHK("fl_lv0", b_lv[2:0], 3'd0)
    `CHK("fl_lv1", b_lv[5:3], 3'd3)
    `CHK("fl_valid", b_ov, 2'b10)
    for (int k = 0; k < 3; k++) begin
      b_or = 2'b10; #1;
      checks++;
      if (b_od[15:8] !== 8'(8'h60 + k)) begin
        errors++;
        $error("FAIL fl_ch1_data: observed %0h expected %0h",
               b_od[15:8], 8'(8'h60 + k));
      end
      @(posedge clk); #1;
    end
    b_or = '0; #1;
    `CHK("fl_ch1_empty", b_lv[5:3], 3'd0)

    for (int k = 0; k < 4; k++) begin
      b_iv = 2'b01; b_id[7:0] = 8'(8'h70 + k);
      @(posedge clk); #1;
    end
    b_id[7:0] = 8'h7F;
    a_or = 2'b10;
    @(posedge clk); #1;
    b_iv = '0; a_or = '0; #1;
    `CHK("ovf_err",  b_er[0], ERR_EN)
    `CHK("ovf_err1", b_er[1], 1'b0)
    `CHK("ovf_level", b_lv[2:0], 3'd4)
    `CHK("udf_err",  a_er[1], ERR_EN)
    `CHK("udf_err0", a_er[0], 1'b0)
    @(posedge clk); #1;
    `CHK("ovf_hold", b_er[0], ERR_EN)
    b_or = 2'b01; #1;
    `CHK("ovf_head", b_od[7:0], 8'h70)
    b_or = '0;
    b_fl = 2'b01; a_fl = 2'b10;
    @(posedge clk); #1;
    b_fl = '0; a_fl = '0; #1;
    `CHK("ovf_clear", b_er[0], 1'b0)
    `CHK("udf_clear", a_er[1], 1'b0)
    `CHK("post_fl_level", b_lv[2:0], 3'd0)

    b_iv = 2'b01; b_id[7:0] = 8'h81;
    @(posedge clk); #1;
    b_id[7:0] = 8'h82;
    @(posedge clk); #1;
    b_iv = '0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    `CHK("rst2_level", b_lv, 6'h0)
    b_iv = 2'b01; b_id[7:0] = 8'h99;
    @(posedge clk); #1;
    b_iv = '0; v = b_od[7:0]; #1;
    `CHK("rst2_first", v, 8'h99)
    `CHK("rst2_lv1", b_lv[2:0], 3'd1)

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
